// File: rtl/decode_stage.sv
// decode_stage: LC-3b pipeline decode stage.
// Holds the DE latch, reads the 8x16 register file, decodes source,
// destination and condition-code usage, detects data/CC hazards and loads
// the AGEX latch (inserting a bubble on a hazard). The register file is
// written here on behalf of the SR stage.
// Build option: define DE_RF_BYPASS_EN to forward a same-cycle SR write to
// the operand reads; otherwise such a write is treated as a hazard.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_de,
  input  logic [15:0] de_npc_in,
  input  logic [15:0] de_ir_in,
  input  logic        de_v_in,
  input  logic        mem_stall,
  input  logic        v_agex_ld_reg,
  input  logic        v_mem_ld_reg,
  input  logic [2:0]  agex_drid_in,
  input  logic [2:0]  mem_drid_in,
  input  logic        v_agex_ld_cc,
  input  logic        v_mem_ld_cc,
  input  logic        v_sr_ld_cc,
  input  logic        v_sr_ld_reg,
  input  logic [2:0]  sr_drid,
  input  logic [15:0] sr_data,
  output logic        dep_stall,
  output logic        v_de_br_stall,
  output logic [15:0] agex_npc,
  output logic [15:0] agex_ir,
  output logic [15:0] agex_sr1,
  output logic [15:0] agex_sr2,
  output logic [2:0]  agex_drid,
  output logic        agex_ld_reg,
  output logic        agex_ld_cc,
  output logic        agex_v
);

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDW = 4'h6, OP_STW  = 4'h7,
    OP_RTI  = 4'h8, OP_XOR = 4'h9, OP_RSA = 4'hA, OP_RSB  = 4'hB,
    OP_JMP  = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } opcode_e;

  // DE latch
  logic [15:0] npc;
  logic [15:0] ir;
  logic        v;

  // Register file
  logic [15:0] rf [8];

  // Decode results
  opcode_e     op;
  logic [2:0]  sr1_addr;
  logic [2:0]  sr2_addr;
  logic [2:0]  dr;
  logic        sr1_used;
  logic        sr2_used;
  logic        ld_reg;
  logic        ld_cc;
  logic        is_ctrl;
  logic [15:0] sr1_val;
  logic [15:0] sr2_val;
  logic        sr1_hit;
  logic        sr2_hit;
  logic        cc_hit;
  logic        issue_v;

  assign op       = opcode_e'(ir[15:12]);
  assign sr1_addr = ir[8:6];

  // Instruction decode: operand selection, destination and CC usage.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sr2_addr = ir[2:0];
    dr       = ir[11:9];
    sr1_used = 1'b0;
    sr2_used = 1'b0;
    ld_reg   = 1'b0;
    ld_cc    = 1'b0;
    is_ctrl  = 1'b0;
    unique case (op)
      OP_ADD, OP_AND, OP_XOR: begin
        sr1_used = 1'b1;
        sr2_used = ~ir[5];
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        sr1_used = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      OP_STB, OP_STW: begin
        sr2_addr = ir[11:9];
        sr1_used = 1'b1;
        sr2_used = 1'b1;
      end
      OP_SHF: begin
        sr1_used = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      OP_LEA: ld_reg = 1'b1;
      OP_JMP: begin
        sr1_used = 1'b1;
        is_ctrl  = 1'b1;
      end
      OP_JSR: begin
        sr1_used = ~ir[11];
        ld_reg   = 1'b1;
        dr       = 3'd7;
        is_ctrl  = 1'b1;
      end
      OP_TRAP: begin
        ld_reg  = 1'b1;
        dr      = 3'd7;
        is_ctrl = 1'b1;
      end
      OP_BR:   is_ctrl = 1'b1;
      default: ;
    endcase
  end

  // Operand read and hazard detection against in-flight register writers.
  always_comb begin
    sr1_val = rf[sr1_addr];
    sr2_val = rf[sr2_addr];
    sr1_hit = (v_agex_ld_reg && (agex_drid_in == sr1_addr)) ||
              (v_mem_ld_reg  && (mem_drid_in  == sr1_addr));
    sr2_hit = (v_agex_ld_reg && (agex_drid_in == sr2_addr)) ||
              (v_mem_ld_reg  && (mem_drid_in  == sr2_addr));
`ifdef DE_RF_BYPASS_EN
    if (v_sr_ld_reg && (sr_drid == sr1_addr)) sr1_val = sr_data;
    if (v_sr_ld_reg && (sr_drid == sr2_addr)) sr2_val = sr_data;
`else
    if (v_sr_ld_reg && (sr_drid == sr1_addr)) sr1_hit = 1'b1;
    if (v_sr_ld_reg && (sr_drid == sr2_addr)) sr2_hit = 1'b1;
`endif
    cc_hit = (op == OP_BR) && (v_agex_ld_cc || v_mem_ld_cc || v_sr_ld_cc);
  end

  assign dep_stall     = v && ((sr1_used && sr1_hit) || (sr2_used && sr2_hit) || cc_hit);
  assign v_de_br_stall = v && is_ctrl;
  assign issue_v       = v && !dep_stall;

  // DE latch: loads from fetch when ld_de, independent of mem_stall.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      npc <= '0;
      ir  <= '0;
      v   <= 1'b0;
    end else if (ld_de) begin
      npc <= de_npc_in;
      ir  <= de_ir_in;
      v   <= de_v_in;
    end
  end

  // Register file write port driven by the SR stage.
  // NOTE: the register file is cleared on reset because the architecture
  // defines all registers as zero after reset; a plain RAM would not be.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (v_sr_ld_reg) begin
      rf[sr_drid] <= sr_data;
    end
  end

  // AGEX latch: loads from DE unless MEM back-pressures; bubbles on hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      agex_npc    <= '0;
      agex_ir     <= '0;
      agex_sr1    <= '0;
      agex_sr2    <= '0;
      agex_drid   <= '0;
      agex_ld_reg <= 1'b0;
      agex_ld_cc  <= 1'b0;
      agex_v      <= 1'b0;
    end else if (!mem_stall) begin
      agex_npc    <= npc;
      agex_ir     <= ir;
      agex_sr1    <= sr1_val;
      agex_sr2    <= sr2_val;
      agex_drid   <= dr;
      agex_ld_reg <= issue_v && ld_reg;
      agex_ld_cc  <= issue_v && ld_cc;
      agex_v      <= issue_v;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_de = 1'b0;
  logic [15:0] de_npc_in = '0;
  logic [15:0] de_ir_in = '0;
  logic        de_v_in = 1'b0;
  logic        mem_stall = 1'b0;
  logic        v_agex_ld_reg = 1'b0;
  logic        v_mem_ld_reg = 1'b0;
  logic [2:0]  agex_drid_in = '0;
  logic [2:0]  mem_drid_in = '0;
  logic        v_agex_ld_cc = 1'b0;
  logic        v_mem_ld_cc = 1'b0;
  logic        v_sr_ld_cc = 1'b0;
  logic        v_sr_ld_reg = 1'b0;
  logic [2:0]  sr_drid = '0;
  logic [15:0] sr_data = '0;
  logic        dep_stall;
  logic        v_de_br_stall;
  logic [15:0] agex_npc;
  logic [15:0] agex_ir;
  logic [15:0] agex_sr1;
  logic [15:0] agex_sr2;
  logic [2:0]  agex_drid;
  logic        agex_ld_reg;
  logic        agex_ld_cc;
  logic        agex_v;

  int total = 0;
  int bad = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .ld_de(ld_de), .de_npc_in(de_npc_in),
    .de_ir_in(de_ir_in), .de_v_in(de_v_in), .mem_stall(mem_stall),
    .v_agex_ld_reg(v_agex_ld_reg), .v_mem_ld_reg(v_mem_ld_reg),
    .agex_drid_in(agex_drid_in), .mem_drid_in(mem_drid_in),
    .v_agex_ld_cc(v_agex_ld_cc), .v_mem_ld_cc(v_mem_ld_cc),
    .v_sr_ld_cc(v_sr_ld_cc), .v_sr_ld_reg(v_sr_ld_reg), .sr_drid(sr_drid),
    .sr_data(sr_data), .dep_stall(dep_stall), .v_de_br_stall(v_de_br_stall),
    .agex_npc(agex_npc), .agex_ir(agex_ir), .agex_sr1(agex_sr1),
    .agex_sr2(agex_sr2), .agex_drid(agex_drid), .agex_ld_reg(agex_ld_reg),
    .agex_ld_cc(agex_ld_cc), .agex_v(agex_v)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one instruction into the DE latch (one edge), then stop loading.
  task automatic load_de(input logic [15:0] ir, input logic [15:0] npc);
    ld_de = 1'b1; de_ir_in = ir; de_npc_in = npc; de_v_in = 1'b1;
    step();
    ld_de = 1'b0;
  endtask

  task automatic sr_write(input logic [2:0] r, input logic [15:0] d);
    v_sr_ld_reg = 1'b1; sr_drid = r; sr_data = d;
    step();
    v_sr_ld_reg = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (agex_v !== 1'b0) begin bad++; $display("FAIL reset_agex_v got=%b want=0", agex_v); end
    total++; if (agex_ir !== 16'h0) begin bad++; $display("FAIL reset_agex_ir got=%h want=0000", agex_ir); end
    total++; if (agex_ld_reg !== 1'b0 || agex_ld_cc !== 1'b0) begin bad++; $display("FAIL reset_ld got=%b%b want=00", agex_ld_reg, agex_ld_cc); end
    total++; if (dep_stall !== 1'b0 || v_de_br_stall !== 1'b0) begin bad++; $display("FAIL reset_stalls got=%b%b want=00", dep_stall, v_de_br_stall); end
  endtask

  task automatic test_add();
    sr_write(3'd2, 16'h0005);
    sr_write(3'd3, 16'h0007);
    load_de(16'h1283, 16'h3002);
    total++; if (dep_stall !== 1'b0) begin bad++; $display("FAIL add_no_stall got=%b want=0", dep_stall); end
    step();
    total++; if (agex_v !== 1'b1) begin bad++; $display("FAIL add_v got=%b want=1", agex_v); end
    total++; if (agex_sr1 !== 16'h0005) begin bad++; $display("FAIL add_sr1 got=%h want=0005", agex_sr1); end
    total++; if (agex_sr2 !== 16'h0007) begin bad++; $display("FAIL add_sr2 got=%h want=0007", agex_sr2); end
    total++; if (agex_drid !== 3'd1) begin bad++; $display("FAIL add_drid got=%0d want=1", agex_drid); end
    total++; if (agex_ld_reg !== 1'b1 || agex_ld_cc !== 1'b1) begin bad++; $display("FAIL add_ld got=%b%b want=11", agex_ld_reg, agex_ld_cc); end
    total++; if (agex_npc !== 16'h3002 || agex_ir !== 16'h1283) begin bad++; $display("FAIL add_npc_ir got=%h/%h want=3002/1283", agex_npc, agex_ir); end
  endtask

  task automatic test_hazard();
    // AGEX writer on SR1 (R2)
    v_agex_ld_reg = 1'b1; agex_drid_in = 3'd2;
    #1;
    total++; if (dep_stall !== 1'b1) begin bad++; $display("FAIL haz_agex_stall got=%b want=1", dep_stall); end
    total++; if (v_de_br_stall !== 1'b0) begin bad++; $display("FAIL haz_br_stall got=%b want=0", v_de_br_stall); end
    step();
    total++; if (agex_v !== 1'b0 || agex_ld_reg !== 1'b0 || agex_ld_cc !== 1'b0) begin bad++; $display("FAIL haz_bubble1 got=%b%b%b want=000", agex_v, agex_ld_reg, agex_ld_cc); end
    step();
    total++; if (agex_v !== 1'b0) begin bad++; $display("FAIL haz_bubble2 got=%b want=0", agex_v); end
    v_agex_ld_reg = 1'b0;
    #1;
    total++; if (dep_stall !== 1'b0) begin bad++; $display("FAIL haz_release got=%b want=0", dep_stall); end
    step();
    total++; if (agex_v !== 1'b1 || agex_sr1 !== 16'h0005) begin bad++; $display("FAIL haz_issue got v=%b sr1=%h want v=1 sr1=0005", agex_v, agex_sr1); end
    // MEM writer on SR2 (R3)
    v_mem_ld_reg = 1'b1; mem_drid_in = 3'd3;
    #1;
    total++; if (dep_stall !== 1'b1) begin bad++; $display("FAIL haz_mem_sr2 got=%b want=1", dep_stall); end
    // ADD R1,R2,#3: SR2 unused, same writer on R3 is not a hazard
    load_de(16'h12A3, 16'h3004);
    total++; if (dep_stall !== 1'b0) begin bad++; $display("FAIL haz_imm_no_stall got=%b want=0", dep_stall); end
    v_mem_ld_reg = 1'b0;
  endtask

  task automatic test_branch();
    load_de(16'h0402, 16'h3006);
    v_mem_ld_cc = 1'b1;
    #1;
    total++; if (dep_stall !== 1'b1 || v_de_br_stall !== 1'b1) begin bad++; $display("FAIL br_cc_stall got=%b%b want=11", dep_stall, v_de_br_stall); end
    step();
    total++; if (agex_v !== 1'b0) begin bad++; $display("FAIL br_bubble got=%b want=0", agex_v); end
    v_mem_ld_cc = 1'b0;
    #1;
    total++; if (dep_stall !== 1'b0 || v_de_br_stall !== 1'b1) begin bad++; $display("FAIL br_clear got=%b%b want=01", dep_stall, v_de_br_stall); end
    step();
    total++; if (agex_v !== 1'b1 || agex_ir !== 16'h0402 || agex_ld_reg !== 1'b0 || agex_ld_cc !== 1'b0) begin bad++; $display("FAIL br_issue got v=%b ir=%h ld=%b%b want v=1 ir=0402 ld=00", agex_v, agex_ir, agex_ld_reg, agex_ld_cc); end
    // TRAP: control flow, writes R7, no CC
    load_de(16'hF025, 16'h3008);
    total++; if (v_de_br_stall !== 1'b1 || dep_stall !== 1'b0) begin bad++; $display("FAIL trap_stalls got=%b%b want=10", v_de_br_stall, dep_stall); end
    step();
    total++; if (agex_drid !== 3'd7 || agex_ld_reg !== 1'b1 || agex_ld_cc !== 1'b0) begin bad++; $display("FAIL trap_dr got drid=%0d ld=%b%b want drid=7 ld=10", agex_drid, agex_ld_reg, agex_ld_cc); end
  endtask

  task automatic test_mem_stall();
    // ld_de and mem_stall together: DE loads, AGEX holds TRAP
    mem_stall = 1'b1;
    load_de(16'h1283, 16'h3010);
    total++; if (agex_ir !== 16'hF025 || agex_npc !== 16'h3008 || agex_v !== 1'b1) begin bad++; $display("FAIL mstall_hold1 got ir=%h npc=%h v=%b want F025/3008/1", agex_ir, agex_npc, agex_v); end
    step();
    total++; if (agex_ir !== 16'hF025 || agex_drid !== 3'd7) begin bad++; $display("FAIL mstall_hold2 got ir=%h drid=%0d want F025/7", agex_ir, agex_drid); end
    step();
    total++; if (agex_ir !== 16'hF025 || agex_ld_reg !== 1'b1) begin bad++; $display("FAIL mstall_hold3 got ir=%h ld_reg=%b want F025/1", agex_ir, agex_ld_reg); end
    mem_stall = 1'b0;
    step();
    total++; if (agex_ir !== 16'h1283 || agex_npc !== 16'h3010 || agex_sr1 !== 16'h0005 || agex_v !== 1'b1) begin bad++; $display("FAIL mstall_release got ir=%h npc=%h sr1=%h v=%b want 1283/3010/0005/1", agex_ir, agex_npc, agex_sr1, agex_v); end
  endtask

  task automatic test_rf_bypass();
    // STW R4, R2, #0
    load_de(16'h7880, 16'h3012);
    v_sr_ld_reg = 1'b1; sr_drid = 3'd4; sr_data = 16'hBEEF;
    #1;
`ifdef DE_RF_BYPASS_EN
    total++; if (dep_stall !== 1'b0) begin bad++; $display("FAIL byp_no_stall got=%b want=0", dep_stall); end
    step();
    v_sr_ld_reg = 1'b0;
    total++; if (agex_v !== 1'b1 || agex_sr2 !== 16'hBEEF) begin bad++; $display("FAIL byp_fwd got v=%b sr2=%h want 1/BEEF", agex_v, agex_sr2); end
`else
    total++; if (dep_stall !== 1'b1) begin bad++; $display("FAIL nobyp_stall got=%b want=1", dep_stall); end
    step();
    v_sr_ld_reg = 1'b0;
    total++; if (agex_v !== 1'b0) begin bad++; $display("FAIL nobyp_bubble got=%b want=0", agex_v); end
    #1;
    step();
    total++; if (agex_v !== 1'b1 || agex_sr2 !== 16'hBEEF) begin bad++; $display("FAIL nobyp_issue got v=%b sr2=%h want 1/BEEF", agex_v, agex_sr2); end
`endif
    total++; if (agex_sr1 !== 16'h0005 || agex_ld_reg !== 1'b0 || agex_ld_cc !== 1'b0) begin bad++; $display("FAIL stw_fields got sr1=%h ld=%b%b want 0005/00", agex_sr1, agex_ld_reg, agex_ld_cc); end
  endtask

  task automatic test_reset_mid_stall();
    v_agex_ld_reg = 1'b1; agex_drid_in = 3'd2;
    #1;
    total++; if (dep_stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%b want=1", dep_stall); end
    // inputs during the reset cycle must be ignored
    reset = 1'b1;
    ld_de = 1'b1; de_ir_in = 16'h1283; de_v_in = 1'b1;
    v_sr_ld_reg = 1'b1; sr_drid = 3'd5; sr_data = 16'h1234;
    step();
    reset = 1'b0; ld_de = 1'b0; v_sr_ld_reg = 1'b0;
    #1;
    total++; if (agex_v !== 1'b0 || agex_ir !== 16'h0 || agex_npc !== 16'h0 || agex_sr1 !== 16'h0 || agex_sr2 !== 16'h0 || agex_drid !== 3'd0) begin bad++; $display("FAIL rst_agex got v=%b ir=%h sr1=%h sr2=%h want all 0", agex_v, agex_ir, agex_sr1, agex_sr2); end
    total++; if (dep_stall !== 1'b0 || v_de_br_stall !== 1'b0) begin bad++; $display("FAIL rst_stalls got=%b%b want=00", dep_stall, v_de_br_stall); end
    v_agex_ld_reg = 1'b0;
    load_de(16'h1283, 16'h3020);
    step();
    total++; if (agex_v !== 1'b1 || agex_sr1 !== 16'h0 || agex_sr2 !== 16'h0) begin bad++; $display("FAIL rst_rf_r2r3 got v=%b sr1=%h sr2=%h want 1/0000/0000", agex_v, agex_sr1, agex_sr2); end
    // ADD R0,R4,R5: R4 was BEEF, R5 write was during reset
    load_de(16'h1105, 16'h3022);
    step();
    total++; if (agex_sr1 !== 16'h0 || agex_sr2 !== 16'h0 || agex_drid !== 3'd0) begin bad++; $display("FAIL rst_rf_r4r5 got sr1=%h sr2=%h drid=%0d want 0000/0000/0", agex_sr1, agex_sr2, agex_drid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_hazard();
    test_branch();
    test_mem_stall();
    test_rf_bypass();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
